// File: rtl/sram_dma_engine_if.sv
// rtl/sram_dma_engine_if.sv - command handshake and SRAM bus bundle for the SRAM DMA engine
interface sram_dma_engine_if #(
  parameter int BW = 32,
  parameter int AW = 10
);
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [BW-1:0] pattern;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW:0]   count;
  logic          mem_csn;
  logic          mem_wen;
  logic [AW-1:0] mem_a;
  logic [BW-1:0] mem_di;
  logic [BW-1:0] mem_dout;

  // Controller plus SRAM side: issues commands, returns read data.
  modport master (
    output start, mode, src, dst, len, pattern, abort, mem_dout,
    input  busy, done, aborted, count, mem_csn, mem_wen, mem_a, mem_di
  );

  // Engine side: accepts commands, masters the SRAM bus.
  modport slave (
    input  start, mode, src, dst, len, pattern, abort, mem_dout,
    output busy, done, aborted, count, mem_csn, mem_wen, mem_a, mem_di
  );
endinterface

// File: rtl/sram_dma_engine.sv
// rtl/sram_dma_engine.sv - SRAM block copy / pattern fill bus-master engine
module sram_dma_engine #(
  parameter int BW = 32,
  parameter int AW = 10
) (
  input logic              clk,
  input logic              rst,
  sram_dma_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, FILLWR} state_t;

  state_t        state, state_d;
  logic [AW-1:0] src_ptr, src_ptr_d;
  logic [AW-1:0] dst_ptr, dst_ptr_d;
  logic [AW-1:0] a_q, a_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   count_inc;
  logic [BW-1:0] di_q, di_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          csn_q, csn_d;
  logic          wen_q, wen_d;
  logic          last_word;

  assign count_inc = count_q + (AW+1)'(1);
  assign last_word = (count_inc == len_q);

  // Next-state and next-register values; bus outputs are precomputed so they
  // are registered and valid during the cycle of the state they belong to.
  always_comb begin
    state_d   = state;
    src_ptr_d = src_ptr;
    dst_ptr_d = dst_ptr;
    a_d       = a_q;
    len_d     = len_q;
    count_d   = count_q;
    di_d      = di_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    csn_d     = csn_q;
    wen_d     = wen_q;
    case (state)
      IDLE: begin
        csn_d = 1'b1;
        wen_d = 1'b1;
        if (bus.start) begin
          src_ptr_d = bus.src;
          dst_ptr_d = bus.dst;
          len_d     = bus.len;
          count_d   = '0;
          aborted_d = 1'b0;
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else if (!bus.mode) begin
            state_d = RD;
            busy_d  = 1'b1;
            csn_d   = 1'b0;
            wen_d   = 1'b1;
            a_d     = bus.src;
          end else begin
            state_d = FILLWR;
            busy_d  = 1'b1;
            csn_d   = 1'b0;
            wen_d   = 1'b0;
            a_d     = bus.dst;
            di_d    = bus.pattern;
          end
        end
      end
      RD: begin
        src_ptr_d = src_ptr + AW'(1);
        if (bus.abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          csn_d     = 1'b1;
          wen_d     = 1'b1;
        end else begin
          state_d = WR;
          wen_d   = 1'b0;
          a_d     = dst_ptr;
        end
      end
      WR: begin
        dst_ptr_d = dst_ptr + AW'(1);
        count_d   = count_inc;
        // Keep the last written word so MEM_DI holds steady once idle.
        di_d      = bus.mem_dout;
        if (bus.abort || last_word) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = bus.abort;
          csn_d     = 1'b1;
          wen_d     = 1'b1;
        end else begin
          state_d = RD;
          wen_d   = 1'b1;
          a_d     = src_ptr;
        end
      end
      FILLWR: begin
        dst_ptr_d = dst_ptr + AW'(1);
        count_d   = count_inc;
        if (bus.abort || last_word) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = bus.abort;
          csn_d     = 1'b1;
          wen_d     = 1'b1;
        end else begin
          a_d = dst_ptr + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      a_q       <= '0;
      len_q     <= '0;
      count_q   <= '0;
      di_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
    end else begin
      state     <= state_d;
      src_ptr   <= src_ptr_d;
      dst_ptr   <= dst_ptr_d;
      a_q       <= a_d;
      len_q     <= len_d;
      count_q   <= count_d;
      di_q      <= di_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      csn_q     <= csn_d;
      wen_q     <= wen_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;
  assign bus.count   = count_q;
  assign bus.mem_csn = csn_q;
  assign bus.mem_wen = wen_q;
  assign bus.mem_a   = a_q;
  // Copy writes forward the read data straight through to the write port.
  assign bus.mem_di  = (state == WR) ? bus.mem_dout : di_q;

endmodule

// File: doc/sram_dma_engine.md
Name: sram_dma_engine

Overview:
- Bus-master engine that drives the single-port synchronous SRAM interface (CSN/WEN/A/DI/DOUT, 1-cycle read latency) on behalf of a controller.
- Performs block COPY (SRAM to SRAM, forward order) and block FILL (pattern write) with a START/BUSY/DONE handshake.
- Sits between the control logic and one SRAM instance. It is the only master of that SRAM while BUSY=1.

Parameters:
- BW, 32, data width; must match the attached SRAM BW.
- AW, 10, address width; must match the attached SRAM AW.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  command strobe; sampled only when BUSY=0.
- MODE  input  1  0=COPY, 1=FILL; captured with START.
- SRC  input  AW  COPY source start address; captured with START.
- DST  input  AW  destination start address; captured with START.
- LEN  input  AW+1  word count, 0..2^AW; captured with START.
- PATTERN  input  BW  FILL data; captured with START.
- ABORT  input  1  early-termination request; sampled only when BUSY=1.
- BUSY  output  1  1 while a command is in progress.
- DONE  output  1  one-cycle completion pulse.
- ABORTED  output  1  valid with DONE; 1 if the command ended via ABORT.
- COUNT  output  AW+1  words written by the current/last command.
- MEM_CSN  output  1  SRAM chip select, active low.
- MEM_WEN  output  1  SRAM 1=read, 0=write.
- MEM_A  output  AW  SRAM address.
- MEM_DI  output  BW  SRAM write data.
- MEM_DOUT  input  BW  SRAM read data, valid one cycle after the read edge.

Behaviour:
- Reset values:
  - BUSY=0, DONE=0, ABORTED=0, COUNT=0.
  - MEM_CSN=1, MEM_WEN=1, MEM_A=0, MEM_DI=0.
  - State=IDLE.
- RST mid-command: returns to IDLE on that edge with the values above. No DONE pulse. Already-written words stay in SRAM.
- States: IDLE, RD, WR, FILLWR. DONE is a registered one-cycle pulse, issued on the edge that returns to IDLE.
- Command capture and state entry, at edge E0 with IDLE and START=1:
  - Capture all command fields; COUNT<=0.
  - LEN=0: stay IDLE, DONE=1, ABORTED=0 for the following cycle, BUSY stays 0. No SRAM access.
  - COPY: go to RD with BUSY=1.
  - FILL: go to FILLWR with BUSY=1.
- Address and bus signals:
  - All MEM_CSN/WEN/A outputs are registered and present during the cycle of the state they belong to.
  - Pointers wrap modulo 2^AW.
- RD cycle: MEM_CSN=0, MEM_WEN=1, MEM_A=src_ptr. Next edge: go to WR, src_ptr+1.
- WR cycle:
  - MEM_CSN=0, MEM_WEN=0, MEM_A=dst_ptr.
  - MEM_DI = MEM_DOUT, a combinational pass-through in COPY mode. This is the only combinational path.
  - Next edge: dst_ptr+1, COUNT+1. Go to RD, or end the command if COUNT+1==LEN.
- COPY throughput: 2 cycles per word. N words take edges E1..E(2N); DONE is high in the cycle after E(2N).
- FILLWR cycle:
  - MEM_CSN=0, MEM_WEN=0, MEM_A=dst_ptr, MEM_DI=PATTERN (captured value).
  - Each edge: dst_ptr+1, COUNT+1. After N words, DONE is high in the cycle after E(N).
- IDLE bus signals: MEM_CSN=1, MEM_WEN=1. MEM_A and MEM_DI hold their last values.
- Command end: BUSY falls on the same edge DONE rises.
- COUNT: holds its final value until the next accepted START.
- Overlap: COPY is strictly forward, word by word. With DST in (SRC, SRC+LEN) the source is overwritten before it is read, and the engine still copies whatever it reads (replicating semantics). This is defined behaviour, not an error.
- ABORT handling:
  - In RD: the read completes, no write follows. End the command; DONE=1, ABORTED=1.
  - In WR or FILLWR: the in-flight write completes and COUNT increments. Then end the command with ABORTED=1.
  - If ABORT coincides with the final write, the command ends with ABORTED=1.
- START while BUSY=1: ignored. ABORT while IDLE: ignored.

Test Plan:
- Reset, then preload SRAM[0x010..0x013]={A0,A1,A2,A3}. COPY SRC=0x010 DST=0x100 LEN=4 → 8 BUSY cycles, alternating RD/WR on the bus, DONE pulse at E8, COUNT=4, SRAM[0x100..0x103]={A0..A3}.
- FILL DST=0x3FE LEN=4 PATTERN=0xDEADBEEF → writes at 0x3FE, 0x3FF, 0x000, 0x001 (wrap), DONE at E4, COUNT=4.
- LEN=0 (either mode) → no CSN=0 cycle, BUSY stays 0, DONE=1 one cycle after START, COUNT=0.
- COPY LEN=8, ABORT pulsed during the 3rd RD cycle → exactly 2 words written, DONE=1, ABORTED=1, COUNT=2. A second START during BUSY is ignored.
- COPY SRC=0x020 DST=0x021 LEN=3 with SRAM[0x020]=0x55 → SRAM[0x021..0x023]=0x55 (forward replication).
- FILL LEN=16, RST asserted at the 5th write cycle → next cycle BUSY=0, DONE=0, CSN=1, COUNT=0. Words 0..3 are written, word 4 is not.
